// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM encoding and default sizing for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ID_WIDTH   = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;
  localparam int STALL_CNT_W    = 16;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first request after index last
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] next,
  output logic          any_req
);
  logic [IW-1:0] w_idx;
  // Walk from farthest to nearest offset so the nearest requester after last wins
  always_comb begin
    w_idx = '0;
    next = last;
    for (int k = N; k >= 1; k--) begin
      w_idx = IW'((int'(last) + k) % N);
      if (req[w_idx]) next = w_idx;
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one sync_fifo write port.
// Define FIFO_WR_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int BCNT_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fifo_wr_en,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                         fifo_full,
  output logic [ID_WIDTH-1:0]          grant_id,
  output logic                         busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]       stall_cnt
`endif
);
  state_t r_state, w_state_nx;
  logic [ID_WIDTH-1:0] r_grant, r_last, w_next;
  logic [BCNT_WIDTH-1:0] r_bcnt;
  logic w_any, w_gnt, w_valid, w_xfer, w_done;
  rr_pick #(.N(NUM_REQ), .IW(ID_WIDTH)) u_pick (
    .req(req_valid), .last(r_last), .next(w_next), .any_req(w_any)
  );
  assign w_gnt   = r_state == GRANT;
  assign w_valid = req_valid[r_grant];
  assign w_xfer  = w_gnt & w_valid & ~fifo_full;
  assign w_done  = w_gnt & (~w_valid | (w_xfer & (r_bcnt == BCNT_WIDTH'(MAX_BURST - 1))));
  always_comb begin
    w_state_nx   = w_done ? IDLE : ((r_state == IDLE && w_any) ? GRANT : r_state);
    req_ready    = (w_gnt & ~fifo_full) ? NUM_REQ'(1) << r_grant : '0;
    fifo_wr_en   = w_xfer;
    fifo_wr_data = w_gnt ? {r_grant, req_data[int'(r_grant) * DATA_WIDTH +: DATA_WIDTH]} : '0;
  end
  assign grant_id = r_grant;
  assign busy     = w_gnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= ID_WIDTH'(NUM_REQ - 1);
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && w_any) r_grant <= w_next;
      if (w_done) begin
        r_last <= r_grant;
        r_bcnt <= '0;
      end else if (w_xfer) r_bcnt <= r_bcnt + 1'b1;
    end
  end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall;
  always_ff @(posedge clk) begin
    if (rst) r_stall <= '0;
    else if (w_gnt & w_valid & fifo_full & ~&r_stall) r_stall <= r_stall + 1'b1;
  end
  assign stall_cnt = r_stall;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed + random checks of fifo_wr_arbiter against a behavioural model and queue FIFO
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;
  localparam int N = 4, IW = 2, DW = 8, MB = 4, DEPTH = 8;
  logic clk = 1'b0;
  logic rst, fifo_wr_en, fifo_full, busy;
  logic [N-1:0] req_valid, req_ready, xfer;
  logic [N*DW-1:0] req_data;
  logic [IW+DW-1:0] fifo_wr_data;
  logic [IW-1:0] grant_id;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int s0;
`endif
  always #5 clk = ~clk;
  fifo_wr_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .DATA_WIDTH(DW), .MAX_BURST(MB), .BCNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  int n_pass, n_chk, m_beats, m_stall;
  int sent [2];
  logic m_busy, force_full, rd_en;
  logic [IW-1:0] m_gid, m_last, ix;
  logic [IW+DW-1:0] fq[$], elog[$], wlog[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  // One clock: check outputs at negedge, advance model and queue FIFO, return just after posedge
  task automatic step();
    logic [N-1:0] e_rdy;
    logic e_wen;
    logic [IW+DW-1:0] e_wd, got;
    fifo_full = force_full || fq.size() >= DEPTH;
    @(negedge clk);
    e_rdy = (m_busy && !fifo_full) ? N'(1) << m_gid : '0;
    e_wen = m_busy && req_valid[m_gid] && !fifo_full;
    e_wd  = m_busy ? {m_gid, req_data[int'(m_gid) * DW +: DW]} : '0;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("wr_en", 32'(fifo_wr_en), 32'(e_wen));
    chk("wr_data", 32'(fifo_wr_data), 32'(e_wd));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (fifo_full) chk("wr_when_full", 32'(fifo_wr_en), 32'd0);
    xfer = req_valid & req_ready;
    if (rd_en && fq.size() > 0) begin
      got = fq.pop_front();
      chk("fifo_out", 32'(got), elog.size() > 0 ? 32'(elog.pop_front()) : 32'hDEAD);
    end
    if (e_wen) elog.push_back(e_wd);
    if (fifo_wr_en && !fifo_full) begin
      fq.push_back(fifo_wr_data);
      wlog.push_back(fifo_wr_data);
    end
    if (rst) begin
      m_busy = 0; m_gid = '0; m_last = IW'(N - 1); m_beats = 0; m_stall = 0;
    end else begin
      if (m_busy && req_valid[m_gid] && fifo_full && m_stall < 65535) m_stall++;
      if (!m_busy) begin
        for (int k = 1; k <= N && !m_busy; k++) begin
          ix = IW'((int'(m_last) + k) % N);
          if (req_valid[ix]) begin m_gid = ix; m_busy = 1; m_beats = 0; end
        end
      end else if (!req_valid[m_gid]) begin
        m_busy = 0; m_last = m_gid; m_beats = 0;
      end else if (!fifo_full) begin
        m_beats++;
        if (m_beats == MB) begin m_busy = 0; m_last = m_gid; m_beats = 0; end
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    n_pass = 0; n_chk = 0; force_full = 0; rd_en = 1; rst = 1; fifo_full = 0;
    req_valid = '1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
    m_busy = 0; m_gid = '0; m_last = IW'(N - 1); m_beats = 0; m_stall = 0;
    @(posedge clk);
    #1;
    repeat (3) step();
    rst = 0;
    wlog.delete();
    repeat (20) step();
    chk("rr_count", 32'(wlog.size()), 32'd16);
    for (int k = 0; k < 16 && k < wlog.size(); k++)
      chk("rr_seq", 32'(wlog[k]), 32'({2'(k / 4), 8'hA0 + 8'(k / 4)}));
    wlog.delete();
    req_valid = 4'b0100; req_data[16 +: 8] = 8'hA5;
    step(); step();
    req_data[16 +: 8] = 8'hA6;
    step();
    req_valid = '0;
    step();
    chk("drop_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("drop_b0", 32'(wlog[0]), 32'h2A5);
      chk("drop_b1", 32'(wlog[1]), 32'h2A6);
    end
    chk("drop_idle", 32'(busy), 32'd0);
    wlog.delete();
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    s0 = int'(stall_cnt);
`endif
    req_valid = 4'b0010; req_data[8 +: 8] = 8'h10;
    step(); step();
    req_data[8 +: 8] = 8'h11;
    step();
    req_data[8 +: 8] = 8'h12; force_full = 1;
    repeat (5) step();
    chk("bp_gid", 32'(grant_id), 32'd1);
    chk("bp_held", 32'(wlog.size()), 32'd2);
    force_full = 0;
    step();
    req_data[8 +: 8] = 8'h13;
    step();
    chk("bp_total", 32'(wlog.size()), 32'd4);
    chk("bp_idle", 32'(busy), 32'd0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    chk("bp_stalls", 32'(int'(stall_cnt) - s0), 32'd5);
`endif
    req_valid = 4'b1000;
    repeat (3) step();
    rst = 1;
    step();
    chk("rst_wen", 32'(fifo_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    rst = 0; req_valid = 4'b1011;
    step(); step();
    chk("post_rst_gid", 32'(grant_id), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd1);
    req_valid = '0;
    repeat (4) step();
    wlog.delete(); rd_en = 0; sent = '{0, 0};
    req_valid = 4'b0011; req_data[0 +: 8] = 8'h60; req_data[8 +: 8] = 8'h70;
    repeat (30) begin
      step();
      for (int i = 0; i < 2; i++)
        if (xfer[i]) begin
          sent[i]++;
          req_data[i*DW +: DW] = 8'(8'h60 + 8'(16 * i) + 8'(sent[i]));
          if (sent[i] == 6) req_valid[i] = 0;
        end
    end
    chk("int_writes", 32'(wlog.size()), 32'd8);
    chk("int_ready", 32'(req_ready), 32'd0);
    req_valid = '0; rd_en = 1;
    repeat (10) step();
    repeat (600) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || xfer[i]) begin
          req_valid[i] = $urandom_range(0, 99) < 60;
          req_data[i*DW +: DW] = 8'($urandom);
        end else if ($urandom_range(0, 99) < 10) req_valid[i] = 0;
      rd_en = $urandom_range(0, 99) < 50;
      force_full = $urandom_range(0, 99) < 10;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
